// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and access-size helpers for the data-memory
// load/store unit.
package dmem_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_DONE,
        S_RESP
    } state_t;

    // Access size in bytes; 0 marks an illegal type encoding.
    function automatic logic [2:0] size_from_type(input logic       we,
                                                  input logic [2:0] lt,
                                                  input logic [1:0] st);
        logic [2:0] sz;
        sz = 3'd0;
        if (we) begin
            case (st)
                ST_SB:   sz = 3'd1;
                ST_SH:   sz = 3'd2;
                ST_SW:   sz = 3'd4;
                default: sz = 3'd0;
            endcase
        end else begin
            case (lt)
                LT_LB, LT_LBU: sz = 3'd1;
                LT_LH, LT_LHU: sz = 3'd2;
                LT_LW:         sz = 3'd4;
                default:       sz = 3'd0;
            endcase
        end
        return sz;
    endfunction

    function automatic logic type_legal(input logic       we,
                                        input logic [2:0] lt,
                                        input logic [1:0] st);
        return size_from_type(we, lt, st) != 3'd0;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the MEM stage (master) and the
// load/store unit (slave).
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_load_type;
    logic [1:0]  req_store_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_load_type, req_store_type, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_load_type, req_store_type, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port
// (read data valid the cycle after the address).
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one request in flight, misaligned accesses optionally split
// into two word beats, extended load data returned on a valid/ready response.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_lsu_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LAST_BYTE = 33'(DEPTH_WORDS * 4 - 1);

    state_t        r_state, w_state_nxt;
    logic          r_we;
    logic [2:0]    r_ltype;
    logic [1:0]    r_off;
    logic [AW-1:0] r_word;
    logic [31:0]   r_wdata;
    logic [7:0]    r_mask;
    logic          r_split;
    logic [31:0]   r_lo;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [2:0]    w_size;
    logic [7:0]    w_mask;
    logic          w_split;
    logic [32:0]   w_last;
    logic          w_acc_err;
    logic [63:0]   w_lane;
    logic [AW-1:0] w_bank_addr;
    logic          w_bank_we;
    logic [3:0]    w_bank_be;
    logic [31:0]   w_bank_wdata;
    logic [31:0]   w_bank_rdata;
    logic [31:0]   w_lo;
    logic [31:0]   w_word;
    logic [31:0]   w_ext;

    // Accept-time decode: byte-lane mask across two words and the error check.
    always_comb begin
        w_size = size_from_type(bus.req_we, bus.req_load_type, bus.req_store_type);
        case (w_size)
            3'd1:    w_mask = 8'h01 << bus.req_addr[1:0];
            3'd2:    w_mask = 8'h03 << bus.req_addr[1:0];
            3'd4:    w_mask = 8'h0F << bus.req_addr[1:0];
            default: w_mask = 8'h00;
        endcase
        w_split   = |w_mask[7:4];
        w_last    = {1'b0, bus.req_addr} + {30'd0, w_size} - 33'd1;
        w_acc_err = !type_legal(bus.req_we, bus.req_load_type, bus.req_store_type)
                    || (w_last > LAST_BYTE)
                    || (w_split && (MISALIGN_SPLIT == 0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_state_nxt = w_acc_err ? S_RESP : S_BEAT0;
            S_BEAT0: w_state_nxt = r_split ? S_BEAT1 : S_DONE;
            S_BEAT1: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat addressing; writes are gated by rst_n so a reset in BEAT1 commits nothing.
    assign w_lane       = {32'd0, r_wdata} << {r_off, 3'b000};
    assign w_bank_addr  = (r_state == S_BEAT1) ? r_word + AW'(1) : r_word;
    assign w_bank_we    = rst_n && r_we && ((r_state == S_BEAT0) || (r_state == S_BEAT1));
    assign w_bank_be    = (r_state == S_BEAT1) ? r_mask[7:4] : r_mask[3:0];
    assign w_bank_wdata = (r_state == S_BEAT1) ? w_lane[63:32] : w_lane[31:0];

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk    (clk),
        .i_addr (w_bank_addr),
        .i_we   (w_bank_we),
        .i_be   (w_bank_be),
        .i_wdata(w_bank_wdata),
        .o_rdata(w_bank_rdata)
    );

    // In DONE the bank holds word A (aligned) or word A+1 (split, A parked in r_lo).
    assign w_lo   = r_split ? r_lo : w_bank_rdata;
    assign w_word = 32'({w_bank_rdata, w_lo} >> {r_off, 3'b000});

    always_comb begin
        case (r_ltype)
            LT_LB:   w_ext = {{24{w_word[7]}}, w_word[7:0]};
            LT_LH:   w_ext = {{16{w_word[15]}}, w_word[15:0]};
            LT_LBU:  w_ext = {24'd0, w_word[7:0]};
            LT_LHU:  w_ext = {16'd0, w_word[15:0]};
            default: w_ext = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_we    <= bus.req_we;
                    r_ltype <= bus.req_load_type;
                    r_off   <= bus.req_addr[1:0];
                    r_word  <= bus.req_addr[AW+1:2];
                    r_wdata <= bus.req_wdata;
                    r_mask  <= w_mask;
                    r_split <= w_split;
                    r_err   <= w_acc_err;
                    r_rdata <= 32'd0;
                end
                S_BEAT1: r_lo    <= w_bank_rdata;
                S_DONE:  r_rdata <= r_we ? 32'd0 : w_ext;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = rst_n && (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: one split-enabled and one split-disabled instance.
module tb_dmem_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        t_valid0 = 1'b0, t_valid1 = 1'b0, t_we = 1'b0, t_rsp_ready = 1'b1;
    logic [2:0]  t_lt = 3'b000;
    logic [1:0]  t_st = 2'b00;
    logic [31:0] t_addr = 32'd0, t_wdata = 32'd0;

    dmem_lsu_if bus0();
    dmem_lsu_if bus1();

    assign bus0.req_valid = t_valid0;      assign bus1.req_valid = t_valid1;
    assign bus0.req_we = t_we;             assign bus1.req_we = t_we;
    assign bus0.req_load_type = t_lt;      assign bus1.req_load_type = t_lt;
    assign bus0.req_store_type = t_st;     assign bus1.req_store_type = t_st;
    assign bus0.req_addr = t_addr;         assign bus1.req_addr = t_addr;
    assign bus0.req_wdata = t_wdata;       assign bus1.req_wdata = t_wdata;
    assign bus0.rsp_ready = t_rsp_ready;   assign bus1.rsp_ready = t_rsp_ready;

    dmem_lsu #(.DEPTH_WORDS(1024), .MISALIGN_SPLIT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_lsu #(.DEPTH_WORDS(1024), .MISALIGN_SPLIT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011, LHU = 3'b100;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

    function automatic logic f_ready(input int sel);
        return (sel == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction
    function automatic logic f_rvalid(input int sel);
        return (sel == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic [31:0] f_rdata(input int sel);
        return (sel == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
    endfunction
    function automatic logic f_rerr(input int sel);
        return (sel == 0) ? bus0.rsp_err : bus1.rsp_err;
    endfunction

    // Drive one request, measure latency in cycles from the accepting edge, compare response.
    task automatic run_req(input int sel, input logic we, input logic [2:0] lt, input logic [1:0] st,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] erd, input logic eerr, input int elat, input string name);
        exp_t e;
        int   n;
        bit   got;
        e.rdata = erd; e.err = eerr; e.lat = elat;
        sb_q.push_back(e);
        @(negedge clk);
        t_we = we; t_lt = lt; t_st = st; t_addr = addr; t_wdata = wdata;
        if (sel == 0) t_valid0 = 1'b1; else t_valid1 = 1'b1;
        n = 0;
        while (!f_ready(sel) && n < 20) begin @(negedge clk); n++; end
        n_cmp++;
        if (!f_ready(sel)) begin
            n_bad++; $display("FAIL %s accept: req_ready=%0b required 1", name, f_ready(sel));
        end
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            t_valid0 = 1'b0; t_valid1 = 1'b0;
            if (f_rvalid(sel)) got = 1;
        end
        e = sb_q.pop_front();
        n_cmp += 4;
        if (!got) begin
            n_bad++; $display("FAIL %s timeout: no rsp_valid within %0d cycles", name, n);
        end
        if (n !== e.lat) begin
            n_bad++; $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
        end
        if (f_rdata(sel) !== e.rdata) begin
            n_bad++; $display("FAIL %s rdata: got %h required %h", name, f_rdata(sel), e.rdata);
        end
        if (f_rerr(sel) !== e.err) begin
            n_bad++; $display("FAIL %s err: got %b required %b", name, f_rerr(sel), e.err);
        end
        n_cmp++;
        if (f_ready(sel) !== 1'b0) begin
            n_bad++; $display("FAIL %s ready_in_resp: got %b required 0", name, f_ready(sel));
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 4;
        if (bus0.rsp_valid !== 1'b0 || bus1.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset rsp_valid: got %b/%b required 0/0", bus0.rsp_valid, bus1.rsp_valid);
        end
        if (bus0.rsp_rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset rsp_rdata: got %h required 0", bus0.rsp_rdata);
        end
        if (bus0.rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL reset rsp_err: got %b required 0", bus0.rsp_err);
        end
        if (bus0.req_ready !== 1'b0 || bus1.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset req_ready_low: got %b/%b required 0/0", bus0.req_ready, bus1.req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus0.req_ready !== 1'b1 || bus1.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset req_ready_after: got %b/%b required 1/1", bus0.req_ready, bus1.req_ready);
        end
    endtask

    task automatic test_aligned();
        run_req(0, 1, LW, SW, 32'h10, 32'hAABBCCDD, 32'h0, 0, 3, "sw10");
        run_req(0, 0, LW, SW, 32'h10, 32'h0, 32'hAABBCCDD, 0, 3, "lw10");
    endtask

    task automatic test_byte();
        run_req(0, 1, LW, SW, 32'h14, 32'h44332211, 32'h0, 0, 3, "sw14");
        run_req(0, 1, LW, SB, 32'h15, 32'hFFFFFF80, 32'h0, 0, 3, "sb15");
        run_req(0, 0, LB, SW, 32'h15, 32'h0, 32'hFFFFFF80, 0, 3, "lb15");
        run_req(0, 0, LBU, SW, 32'h15, 32'h0, 32'h00000080, 0, 3, "lbu15");
        run_req(0, 0, LW, SW, 32'h14, 32'h0, 32'h44338011, 0, 3, "lw14_neighbours");
    endtask

    task automatic test_range();
        run_req(0, 0, LW, SW, 32'h1000, 32'h0, 32'h0, 1, 1, "lw1000_err");
        run_req(0, 0, LW, SW, 32'hFFE, 32'h0, 32'h0, 1, 1, "lwffe_err");
        run_req(0, 1, LW, SW, 32'hFFC, 32'h12345678, 32'h0, 0, 3, "swffc");
        run_req(0, 0, LH, SW, 32'hFFE, 32'h0, 32'h00001234, 0, 3, "lhffe");
        run_req(0, 1, LW, 2'b11, 32'h10, 32'hDEADBEEF, 32'h0, 1, 1, "st11_err");
        run_req(0, 0, 3'b101, SW, 32'h10, 32'h0, 32'h0, 1, 1, "lt101_err");
        run_req(0, 0, LW, SW, 32'h10, 32'h0, 32'hAABBCCDD, 0, 3, "lw10_nowrite");
    endtask

    task automatic test_split();
        run_req(0, 1, LW, SH, 32'h23, 32'h00008001, 32'h0, 0, 4, "sh23");
        run_req(0, 0, LBU, SW, 32'h23, 32'h0, 32'h01, 0, 3, "lbu23");
        run_req(0, 0, LBU, SW, 32'h24, 32'h0, 32'h80, 0, 3, "lbu24");
        run_req(0, 0, LH, SW, 32'h23, 32'h0, 32'hFFFF8001, 0, 4, "lh23");
        run_req(0, 0, LHU, SW, 32'h23, 32'h0, 32'h00008001, 0, 4, "lhu23");
        run_req(0, 1, LW, SW, 32'h12, 32'h11223344, 32'h0, 0, 4, "sw12");
        run_req(0, 0, LW, SW, 32'h12, 32'h0, 32'h11223344, 0, 4, "lw12");
    endtask

    task automatic test_nosplit();
        run_req(1, 1, LW, SW, 32'h10, 32'h55667788, 32'h0, 0, 3, "ns_sw10");
        run_req(1, 1, LW, SW, 32'h12, 32'h99999999, 32'h0, 1, 1, "ns_sw12_err");
        run_req(1, 0, LW, SW, 32'h10, 32'h0, 32'h55667788, 0, 3, "ns_lw10");
        run_req(1, 1, LW, SW, 32'h20, 32'hCAFEBEEF, 32'h0, 0, 3, "ns_sw20");
        run_req(1, 0, LH, SW, 32'h21, 32'h0, 32'hFFFFFEBE, 0, 3, "ns_lh21");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        run_req(0, 1, LW, SW, 32'h40, 32'h0BADF00D, 32'h0, 0, 3, "bp_sw40");
        run_req(0, 1, LW, SW, 32'h44, 32'h0, 32'h0, 0, 3, "bp_sw44");
        e.rdata = 32'h0BADF00D; e.err = 1'b0; e.lat = 3;
        sb_q.push_back(e);
        @(negedge clk);
        t_rsp_ready = 1'b0;
        t_we = 1'b0; t_lt = LW; t_addr = 32'h40; t_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_we = 1'b1; t_st = SW; t_addr = 32'h44; t_wdata = 32'hFFFFFFFF;
        n = 0;
        while (!bus0.rsp_valid && n < 20) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_cmp += 3;
            if (bus0.rsp_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp hold%0d rsp_valid: got %b required 1", k, bus0.rsp_valid);
            end
            if (bus0.rsp_rdata !== e.rdata) begin
                n_bad++; $display("FAIL bp hold%0d rdata: got %h required %h", k, bus0.rsp_rdata, e.rdata);
            end
            if (bus0.req_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp hold%0d req_ready: got %b required 0", k, bus0.req_ready);
            end
            @(negedge clk);
        end
        t_valid0 = 1'b0;
        t_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp release: valid/ready %b/%b required 0/1", bus0.rsp_valid, bus0.req_ready);
        end
        run_req(0, 0, LW, SW, 32'h44, 32'h0, 32'h0, 0, 3, "bp_lw44_not_written");
    endtask

    task automatic test_reset_mid();
        int k;
        run_req(0, 1, LW, SW, 32'h30, 32'h0, 32'h0, 0, 3, "rm_sw30");
        run_req(0, 1, LW, SW, 32'h34, 32'h0, 32'h0, 0, 3, "rm_sw34");
        @(negedge clk);
        t_we = 1'b1; t_st = SW; t_addr = 32'h32; t_wdata = 32'hA1B2C3D4; t_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (bus0.rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rm rsp_valid: got %b required 0", bus0.rsp_valid);
        end
        if (bus0.req_ready !== 1'b0) begin
            n_bad++; $display("FAIL rm req_ready_in_reset: got %b required 0", bus0.req_ready);
        end
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.rsp_valid) k++;
        end
        n_cmp++;
        if (k != 0) begin
            n_bad++; $display("FAIL rm stray_response: got %0d valid cycles required 0", k);
        end
        run_req(0, 0, LW, SW, 32'h30, 32'h0, 32'hC3D40000, 0, 3, "rm_lw30_beat0");
        run_req(0, 0, LW, SW, 32'h34, 32'h0, 32'h00000000, 0, 3, "rm_lw34_beat1");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned();
        test_byte();
        test_range();
        test_split();
        test_nosplit();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised load/store unit for the RISC-V data memory subsystem, the successor to the combinational-store / single-cycle-memory data path. It accepts one load or store per valid/ready request, performs the access on an internal byte-lane synchronous-read RAM, splits misaligned accesses into two word beats, and returns sign- or zero-extended load data and an error flag on a valid/ready response channel. It sits between the pipeline's MEM stage and the data RAM.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words (power of two, ≥2); byte address space is 0 to DEPTH_WORDS*4-1.
- MISALIGN_SPLIT, 1: 1 = misaligned access split into two beats; 0 = misaligned access returns error with no memory effect.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_load_type  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; 101–111 illegal.
- req_store_type  in  2  00 SB, 01 SH, 10 SW; 11 illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (rs2).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal type, out-of-range, or misaligned with MISALIGN_SPLIT=0.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE, RESP. One request in flight; no pipelining.
- IDLE: req_ready=1. Accept on req_valid & req_ready; register we, type, addr, wdata. size = 1/2/4 bytes; off = addr[1:0]; A = addr>>2.
- Error check at accept: illegal type, or addr+size-1 > DEPTH_WORDS*4-1 (computed 33-bit, no wrap), or (misaligned and MISALIGN_SPLIT=0) → RESP with rsp_err=1, no RAM access.
- Misaligned = off+size > 4 (LH/SH at off 3; LW/SW at off 1–3). Aligned-in-word halfword at off 1 is NOT misaligned.
- IDLE → BEAT0 (no error). BEAT0 accesses word A. Split → BEAT1 (word A+1), else → DONE. BEAT1 → DONE. DONE → RESP.
- Store: data shifted left by off*8 into a 64-bit lane image; beat0 writes bytes off..min(3,off+size-1) of word A; beat1 writes bytes 0..off+size-5 of word A+1. Byte enables only; other bytes untouched.
- Load: RAM read is synchronous (data one cycle after address). Word A captured as lo in cycle after BEAT0, word A+1 as hi in DONE; {hi,lo}>>(off*8), low size bytes extended: LB/LH sign, LBU/LHU zero, LW none.
- RESP: rsp_valid=1; rsp_rdata/rsp_err stable until rsp_ready; on rsp_valid & rsp_ready → IDLE. req_ready=0 in all states but IDLE.

## Timing
- Reset (rst_n low at an edge): state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready 0 while rst_n low, 1 the first cycle after release. RAM contents not reset.
- Accept at edge T: aligned access rsp_valid from cycle T+3; split T+4; error T+1.
- Store bytes visible to a load accepted any cycle after the store's response.
- Earliest next accept: the cycle after the response handshake (req_ready not asserted in the handshake cycle).
- Reset mid-operation: abort immediately; no response. Beat already written stays written (split store reset in BEAT1 leaves beat0 bytes committed, beat1 bytes not).
- rsp_ready held high with no rsp_valid: no effect.

## Structure
- Package dmem_pkg: load/store type encodings, state enum, size-from-type function, legality function.
- Sub-module dmem_bank: DEPTH_WORDS×32 RAM, 4 byte-write enables, synchronous read, single port; the FSM and lane/extend logic stay in dmem_lsu.

## Test plan
- SW 0x10 0xAABBCCDD, then LW 0x10 → rsp_rdata 0xAABBCCDD, rsp_err 0, rsp_valid at T+3.
- SB 0x15 0x80; LB 0x15 → 0xFFFFFF80; LBU 0x15 → 0x00000080; bytes 0x14/0x16/0x17 unchanged.
- Split (MISALIGN_SPLIT=1): SH 0x23 0x8001 → byte 0x23=0x01, 0x24=0x80; LH 0x23 → 0xFFFF8001, LHU → 0x00008001, rsp_valid at T+4; SW 0x12 0x11223344, LW 0x12 → 0x11223344.
- MISALIGN_SPLIT=0: SW 0x12 → rsp_err 1 at T+1, LW 0x10 returns prior contents; LH 0x21 → legal, no error.
- Range (DEPTH_WORDS=1024): LW 0x1000 → err; LW 0xFFE → err; LH 0xFFE → legal; store_type 11 → err, no write.
- Backpressure/reset: rsp_ready low 5 cycles → rsp_valid, rsp_rdata stable, req_ready 0, new request not accepted; rst_n low during BEAT1 of split store → IDLE next cycle, rsp_valid 0, beat0 bytes written only.
